// File: rtl/spi_regbank_pkg.sv
// Shared types and constants for the SPI register bank.
package spi_regbank_pkg;

    localparam int ADDR_W       = 7;
    localparam int CMD_BITS     = 8;
    localparam int CMD_WR_BIT   = 7;
    localparam int CMD_ADDR_MSB = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

endpackage

// File: rtl/spi_regbank_phy.sv
// SPI mode-0 front end: input synchronisers, SCLK edge detect, bit counter,
// RX and TX shift registers, all in the clk domain.
module spi_regbank_phy
    import spi_regbank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_cs_n,
    input  logic             spi_clk,
    input  logic             spi_mosi,
    input  logic             active,
    input  logic             in_cmd,
    input  logic             tx_load,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_en,
    output logic             cs_fall,
    output logic             cs_rise,
    output logic             frame_done,
    output logic [WIDTH-1:0] rx_word,
    output logic             miso
);

    localparam int CNT_W = 6;

    logic [2:0]       cs_q;
    logic [2:0]       sclk_q;
    logic [1:0]       mosi_q;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic             sclk_rise;
    logic             sclk_fall;
    logic [CNT_W-1:0] last_bit;

    // CS sync resets to 0 so a CS held low across reset never looks like a new falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q      <= '0;
            sclk_q    <= '0;
            mosi_q    <= '0;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
        end else begin
            cs_q      <= {cs_q[1:0], spi_cs_n};
            sclk_q    <= {sclk_q[1:0], spi_clk};
            mosi_q    <= {mosi_q[0], spi_mosi};
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
        end
    end

    assign cs_fall    = ~cs_q[1] & cs_q[2];
    assign cs_rise    =  cs_q[1] & ~cs_q[2];
    assign sclk_rise  =  sclk_q[1] & ~sclk_q[2];
    assign sclk_fall  = ~sclk_q[1] & sclk_q[2];
    assign last_bit   = in_cmd ? CNT_W'(CMD_BITS - 1) : CNT_W'(WIDTH - 1);
    assign frame_done = active & sclk_rise & (bit_cnt_q == last_bit);
    assign rx_word    = {rx_q[WIDTH-2:0], mosi_q[1]};
    assign miso       = tx_en & tx_q[WIDTH-1];

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        if (!active) begin
            bit_cnt_d = '0;
            rx_d      = '0;
            tx_d      = '0;
        end else begin
            if (sclk_rise) begin
                rx_d      = rx_word;
                bit_cnt_d = frame_done ? '0 : bit_cnt_q + 1'b1;
            end
            // The fall right after a frame's last rise must keep the freshly loaded MSB.
            if (sclk_fall && (bit_cnt_q != '0)) begin
                tx_d = {tx_q[WIDTH-2:0], 1'b0};
            end
            if (tx_load) begin
                tx_d = tx_data;
            end
        end
    end

endmodule

// File: rtl/spi_regbank.sv
// SPI slave register bank: NUM_CFG read/write config registers followed by NUM_STS
// read-only status registers. Define SPI_REGBANK_BURST_EN for auto-increment bursts.
//
// state   | meaning
// IDLE    | CS high, MISO held low
// CMD     | shifting in the 8-bit command byte
// DATA    | shifting WIDTH-bit data frames for the decoded address
module spi_regbank
    import spi_regbank_pkg::*;
#(
    parameter int                       NUM_CFG = 8,
    parameter int                       NUM_STS = 4,
    parameter int                       WIDTH   = 8,
    parameter logic [NUM_CFG*WIDTH-1:0] CFG_RST = '0
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         ena,
    input  logic                                         spi_cs_n,
    input  logic                                         spi_clk,
    input  logic                                         spi_mosi,
    output logic                                         spi_miso,
    input  logic [((NUM_STS > 0) ? NUM_STS : 1)*WIDTH-1:0] status_regs,
    output logic [NUM_CFG*WIDTH-1:0]                     config_regs,
    output logic [NUM_CFG-1:0]                           cfg_wr_stb,
    output logic                                         busy
);

    localparam int TOTAL = NUM_CFG + NUM_STS;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic                skip_q, skip_d;
    logic [NUM_CFG-1:0]  stb_q, stb_d;
    logic [WIDTH-1:0]    cfg_q [NUM_CFG];
    logic [WIDTH-1:0]    cfg_d [NUM_CFG];

    logic                cs_fall, cs_rise, frame_done, tx_load;
    logic [WIDTH-1:0]    rx_word, rd_data;
    logic [ADDR_W-1:0]   cmd_addr, addr_inc, rd_addr;
    logic                wr_hit;

    spi_regbank_phy #(.WIDTH(WIDTH)) u_phy (
        .clk        (clk),
        .rst        (rst),
        .spi_cs_n   (spi_cs_n),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .active     (busy),
        .in_cmd     (state_q == ST_CMD),
        .tx_load    (tx_load),
        .tx_data    (rd_data),
        .tx_en      (busy & ~skip_q),
        .cs_fall    (cs_fall),
        .cs_rise    (cs_rise),
        .frame_done (frame_done),
        .rx_word    (rx_word),
        .miso       (spi_miso)
    );

    assign busy     = (state_q != ST_IDLE);
    assign cmd_addr = rx_word[CMD_ADDR_MSB:0];
    assign addr_inc = (addr_q == ADDR_W'(TOTAL - 1)) ? '0 : addr_q + 1'b1;
    assign rd_addr  = (state_q == ST_CMD) ? cmd_addr : addr_inc;
    assign wr_hit   = (state_q == ST_DATA) && frame_done && !skip_q && wr_q && ena
                      && (addr_q < ADDR_W'(NUM_CFG));

    // Status is sampled at the moment the TX shifter is loaded.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (rd_addr == ADDR_W'(i)) rd_data = cfg_q[i];
        end
        for (int j = 0; j < NUM_STS; j++) begin
            if (rd_addr == ADDR_W'(NUM_CFG + j)) rd_data = status_regs[j*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        skip_d  = skip_q;
        stb_d   = '0;
        tx_load = 1'b0;
        cfg_d   = cfg_q;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_CMD;
                    skip_d  = 1'b0;
                end
            end
            ST_CMD: begin
                if (frame_done) begin
                    state_d = ST_DATA;
                    addr_d  = cmd_addr;
                    wr_d    = rx_word[CMD_WR_BIT];
                    tx_load = 1'b1;
                end
            end
            ST_DATA: begin
                if (frame_done && !skip_q) begin
`ifdef SPI_REGBANK_BURST_EN
                    addr_d  = addr_inc;
                    tx_load = 1'b1;
`else
                    skip_d  = 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
        for (int i = 0; i < NUM_CFG; i++) begin
            if (wr_hit && (addr_q == ADDR_W'(i))) begin
                cfg_d[i] = rx_word;
                stb_d[i] = 1'b1;
            end
        end
        if (cs_rise) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            skip_q  <= 1'b0;
            stb_q   <= '0;
            for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= CFG_RST[i*WIDTH +: WIDTH];
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            skip_q  <= skip_d;
            stb_q   <= stb_d;
            for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= cfg_d[i];
        end
    end

    assign cfg_wr_stb = stb_q;

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
        assign config_regs[g*WIDTH +: WIDTH] = cfg_q[g];
    end

endmodule

// File: doc/spi_regbank.md
SPI_REGBANK -- requirements
Module: spi_regbank

Interface
REQ-001 SHALL have parameter NUM_CFG, default 8, count of read/write config registers (1..64).
REQ-002 SHALL have parameter NUM_STS, default 4, count of read-only status registers (0..64; NUM_CFG+NUM_STS <= 128).
REQ-003 SHALL have parameter WIDTH, default 8, register and data-frame width in bits (8, 16 or 32).
REQ-004 SHALL have parameter CFG_RST, default all-zero, NUM_CFG*WIDTH-bit reset value, register i at bits [i*WIDTH +: WIDTH].
REQ-005 SHALL have ports: clk in 1 system clock; rst in 1 synchronous active-high reset; ena in 1 write enable; spi_cs_n in 1; spi_clk in 1; spi_mosi in 1; spi_miso out 1; status_regs in NUM_STS*WIDTH packed status; config_regs out NUM_CFG*WIDTH packed config; cfg_wr_stb out NUM_CFG per-register write pulse; busy out 1 transaction active.

Function
REQ-006 SHALL use SPI mode 0, MSB first: sample MOSI on SCLK rise, update MISO on SCLK fall; requires f_clk >= 8*f_sclk.
REQ-007 SHALL pass spi_cs_n, spi_clk, spi_mosi through 2-flop synchronisers and detect SCLK edges in the clk domain.
REQ-008 SHALL use FSM IDLE -> CMD on CS fall; CMD -> DATA after 8 bits; DATA -> DATA per WIDTH-bit frame; any state -> IDLE on CS rise.
REQ-009 SHALL decode the command byte as bit7 = write (1) / read (0), bits6:0 = address.
REQ-010 SHALL map addresses 0..NUM_CFG-1 to config and NUM_CFG..NUM_CFG+NUM_STS-1 to status; other addresses are invalid.
REQ-011 SHALL, on command completion, load the addressed register (status sampled then; invalid = 0) into the TX shifter and drive its MSB on spi_miso the next clk.
REQ-012 SHALL, on the clk after the last data-frame rising edge, write a config address when write=1 and ena=1, pulsing that cfg_wr_stb bit for exactly one clk.
REQ-013 SHALL silently ignore writes to status or invalid addresses, and all writes when ena=0 (no strobe).
REQ-014 SHALL discard a partial frame on CS rise mid-frame; no register is modified.
REQ-015 SHALL drive spi_miso = 0 in IDLE, and busy = 1 in CMD/DATA.
REQ-016 SHALL let a same-cycle write to config register k win over nothing else (config is SPI-written only); status_regs never change config.

Reset
REQ-017 SHALL, on clk edge with rst=1: config_regs = CFG_RST, cfg_wr_stb = 0, spi_miso = 0, busy = 0, FSM = IDLE, shifters and bit counters cleared.
REQ-018 SHALL abort any transaction in progress on reset; the transaction is not resumed after rst falls, even with CS still low.

Configuration
REQ-019 SHALL, with SPI_REGBANK_BURST_EN defined, increment the address after each data frame, wrapping from NUM_CFG+NUM_STS-1 to 0, reloading TX for reads.
REQ-020 SHALL, without SPI_REGBANK_BURST_EN, ignore all frames after the first data frame (no writes, spi_miso = 0) until CS rises.

Structure
REQ-021 SHALL take FSM state enum, command-bit positions and address width constant (7) from package spi_regbank_pkg.
REQ-022 SHALL put synchroniser, edge detect, bit counter and RX/TX shifters in sub-module spi_regbank_phy; register file and FSM stay in spi_regbank.

Verification
REQ-023 Reset: rst=1 one clk with CFG_RST = 0x..A5 for reg 0 -> config_regs[7:0] = 0xA5, cfg_wr_stb = 0, busy = 0.
REQ-024 Write: command 0x83, data 0x5C, ena=1 -> config reg 3 = 0x5C, cfg_wr_stb[3] one-clk pulse; same with ena=0 -> unchanged, no pulse.
REQ-025 Read status: status reg 1 = 0x3E, command 0x09 (NUM_CFG=8) -> MISO returns 0x3E; command 0x7F -> 0x00.
REQ-026 CS abort: command 0x82 then 5 data bits, CS rises -> reg 2 unchanged, busy falls, next transaction works.
REQ-027 Burst (macro on): command 0x8B with NUM_CFG=8, NUM_STS=4, three bytes 0x11,0x22,0x33 -> write to 11 ignored, wrap, reg 0 = 0x22, reg 1 = 0x33; macro off -> only first frame acted on.
